// File: rtl/truth_table_pkg.sv
// Shared types and helpers for the truth-table sequencer: FSM state encoding
// and the index-width helper used for the function-select port.
package truth_table_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ceil(log2(n)), but never below 1 so a single-function build still has a port bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tt_lut_bank.sv
// Storage for N_FN truth tables of 2^N_IN bits each: one synchronous write port,
// one combinational read returning every function's bit for the selected row.
module tt_lut_bank
    import truth_table_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int N_FN = 2,
    localparam int FN_W = clog2_min1(N_FN),
    localparam int ROWS = 1 << N_IN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [FN_W-1:0] wr_fn,
    input  logic [ROWS-1:0] wr_data,
    input  logic [N_IN-1:0] rd_row,
    output logic [N_FN-1:0] rd_bits
);

    logic [ROWS-1:0] r_mem [N_FN];

    // An out-of-range function index matches no entry, so the write simply drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int f = 0; f < N_FN; f++) begin
                r_mem[f] <= '0;
            end
        end else begin
            for (int f = 0; f < N_FN; f++) begin
                if (wr_en && (wr_fn == FN_W'(f))) begin
                    r_mem[f] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_bits = '0;
        for (int f = 0; f < N_FN; f++) begin
            rd_bits[f] = r_mem[f][rd_row];
        end
    end

endmodule

// File: rtl/truth_table_seq.sv
// Truth-table sequencer: on start, presents every input row 0..2^N_IN-1 with the
// evaluated function outputs over a valid/ready handshake, then pulses done.
// Optional build macro TRUTH_TABLE_SEQ_MINTERM_COUNT_EN adds per-function minterm counters.
//
// Handshake: a row transfers on any rising edge where row_valid & row_ready are both 1;
// while row_valid is high and row_ready low, row_x/row_s/row_last hold steady and
// row_valid never drops until the transfer happens (or reset aborts the sweep).
module truth_table_seq
    import truth_table_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int N_FN = 2,
    localparam int FN_W = clog2_min1(N_FN),
    localparam int ROWS = 1 << N_IN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            lut_wr_en,
    input  logic [FN_W-1:0] lut_wr_fn,
    input  logic [ROWS-1:0] lut_wr_data,
    output logic            row_valid,
    input  logic            row_ready,
    output logic [N_IN-1:0] row_x,
    output logic [N_FN-1:0] row_s,
    output logic            row_last,
    output logic            busy,
    output logic            done,
    output state_t          dbg_state
`ifdef TRUTH_TABLE_SEQ_MINTERM_COUNT_EN
    ,
    output logic [N_FN*(N_IN+1)-1:0] minterm_cnt
`endif
);

    state_t          r_state;
    state_t          w_next_state;
    logic [N_IN-1:0] r_row;
    logic [N_IN-1:0] w_next_row;
    logic [N_FN-1:0] w_lut_bits;
    logic            w_lut_wr;
    logic            w_is_last;
    logic            w_accept;

    // Tables are writable only while idle, which includes the cycle start is sampled.
    assign w_lut_wr  = lut_wr_en && (r_state == ST_IDLE);
    assign w_is_last = (r_row == N_IN'(ROWS - 1));
    assign w_accept  = (r_state == ST_RUN) && row_ready;

    tt_lut_bank #(
        .N_IN (N_IN),
        .N_FN (N_FN)
    ) u_lut_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_lut_wr),
        .wr_fn   (lut_wr_fn),
        .wr_data (lut_wr_data),
        .rd_row  (r_row),
        .rd_bits (w_lut_bits)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
        end else begin
            r_state <= w_next_state;
            r_row   <= w_next_row;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_row   = r_row;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_RUN;
                    w_next_row   = '0;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    if (w_is_last) begin
                        w_next_state = ST_DONE;
                        w_next_row   = '0;
                    end else begin
                        w_next_row = r_row + N_IN'(1);
                    end
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_row   = '0;
            end
        endcase
    end

    always_comb begin
        row_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        row_x     = '0;
        row_s     = '0;
        row_last  = 1'b0;
        case (r_state)
            ST_RUN: begin
                row_valid = 1'b1;
                busy      = 1'b1;
                row_x     = r_row;
                row_s     = w_lut_bits;
                row_last  = w_is_last;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dbg_state = r_state;

`ifdef TRUTH_TABLE_SEQ_MINTERM_COUNT_EN
    logic [N_FN-1:0][N_IN:0] r_cnt;

    // Counts survive DONE so software can read the last sweep's totals while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            for (int f = 0; f < N_FN; f++) begin
                if (w_lut_bits[f]) begin
                    r_cnt[f] <= r_cnt[f] + (N_IN+1)'(1);
                end
            end
        end
    end

    assign minterm_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_truth_table_seq.sv
// Bench for truth_table_seq: default-size instance driven by directed and random
// sweeps against a table model, plus a 3-input single-function instance for XOR3.
module tb_truth_table_seq;
  import truth_table_pkg::*;

  localparam int N_IN = 2;
  localparam int N_FN = 2;
  localparam int ROWS = 1 << N_IN;
  localparam int W    = 1 + N_IN + N_FN;

  logic clk;
  logic reset;

  // default instance
  logic            start;
  logic            lut_wr_en;
  logic [0:0]      lut_wr_fn;
  logic [ROWS-1:0] lut_wr_data;
  logic            row_valid;
  logic            row_ready;
  logic [N_IN-1:0] row_x;
  logic [N_FN-1:0] row_s;
  logic            row_last;
  logic            busy;
  logic            done;
  state_t          dbg_state;

  // 3-input, 1-function instance
  logic       b_start;
  logic       b_wr_en;
  logic [0:0] b_wr_fn;
  logic [7:0] b_wr_data;
  logic       b_valid;
  logic       b_ready;
  logic [2:0] b_x;
  logic [0:0] b_s;
  logic       b_last;
  logic       b_busy;
  logic       b_done;
  state_t     b_dbg_state;

`ifdef TRUTH_TABLE_SEQ_MINTERM_COUNT_EN
  logic [N_FN*(N_IN+1)-1:0] minterm_cnt;
  logic [3:0]               b_minterm_cnt;
`endif

  truth_table_seq #(.N_IN(N_IN), .N_FN(N_FN)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .lut_wr_en   (lut_wr_en),
    .lut_wr_fn   (lut_wr_fn),
    .lut_wr_data (lut_wr_data),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .row_x       (row_x),
    .row_s       (row_s),
    .row_last    (row_last),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
`ifdef TRUTH_TABLE_SEQ_MINTERM_COUNT_EN
    ,
    .minterm_cnt (minterm_cnt)
`endif
  );

  truth_table_seq #(.N_IN(3), .N_FN(1)) u_dut3 (
    .clk         (clk),
    .reset       (reset),
    .start       (b_start),
    .lut_wr_en   (b_wr_en),
    .lut_wr_fn   (b_wr_fn),
    .lut_wr_data (b_wr_data),
    .row_valid   (b_valid),
    .row_ready   (b_ready),
    .row_x       (b_x),
    .row_s       (b_s),
    .row_last    (b_last),
    .busy        (b_busy),
    .done        (b_done),
    .dbg_state   (b_dbg_state)
`ifdef TRUTH_TABLE_SEQ_MINTERM_COUNT_EN
    ,
    .minterm_cnt (b_minterm_cnt)
`endif
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state
  logic [W-1:0]    exp_q[$];
  logic [ROWS-1:0] model_lut[N_FN];
  int              exp_cnt[N_FN];
  int              n_checks;
  int              n_fail;
  int              done_cnt;
  logic            prev_done;
  logic            held_valid;
  logic [W-1:0]    held_word;

  // last negedge samples
  logic            s_valid;
  logic            s_ready;
  logic            s_busy;
  logic            s_done;
  logic [W-1:0]    s_word;
  state_t          s_state;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Build the expected row stream straight from the truth tables.
  task automatic push_expected();
    logic [N_FN-1:0] s;
    logic [N_IN-1:0] x;
    for (int f = 0; f < N_FN; f++) exp_cnt[f] = 0;
    for (int k = 0; k < ROWS; k++) begin
      for (int f = 0; f < N_FN; f++) begin
        s[f] = model_lut[f][k];
        if (s[f]) exp_cnt[f]++;
      end
      x = N_IN'(k);
      exp_q.push_back({(k == ROWS - 1), x, s});
    end
  endtask

  // One clock: sample and score at negedge, then move to just past the next posedge.
  task automatic step();
    logic [W-1:0] e;
    @(negedge clk);
    s_valid = row_valid;
    s_ready = row_ready;
    s_busy  = busy;
    s_done  = done;
    s_state = dbg_state;
    s_word  = {row_last, row_x, row_s};
    if (reset) begin
      held_valid = 1'b0;
      prev_done  = 1'b0;
    end else begin
      check("busy_eq_valid", 32'(s_busy), 32'(s_valid));
      if (s_valid) begin
        if (held_valid) check("hold_under_backpressure", 32'(s_word), 32'(held_word));
        if (s_ready) begin
          check("row_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("row_word", 32'(s_word), 32'(e));
          end
        end
      end else begin
        check("idle_outputs_zero", 32'(s_word), 32'd0);
      end
      if (s_done) begin
        check("done_one_cycle", 32'(prev_done), 32'd0);
        done_cnt++;
      end
      held_valid = s_valid && !s_ready;
      held_word  = s_word;
      prev_done  = s_done;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_lut(input int fn, input logic [ROWS-1:0] data, input bit expect_take);
    lut_wr_en   = 1'b1;
    lut_wr_fn   = 1'(fn);
    lut_wr_data = data;
    if (expect_take && fn < N_FN) model_lut[fn] = data;
    step();
    lut_wr_en = 1'b0;
  endtask

  // mode: 0 random ready, 1 stall row 1 for three cycles, 2 inject write+start mid-run
  task automatic run_sweep(input int ready_pct, input int mode, input bit wr_at_start,
                           input logic [ROWS-1:0] ws_data);
    int cyc;
    if (wr_at_start) begin
      lut_wr_en   = 1'b1;
      lut_wr_fn   = 1'b1;
      lut_wr_data = ws_data;
      model_lut[1] = ws_data;
    end
    push_expected();
    done_cnt  = 0;
    start     = 1'b1;
    row_ready = 1'b0;
    step();
    check("idle_at_start_cycle", 32'(s_valid), 32'd0);
    start     = 1'b0;
    lut_wr_en = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 300) begin
      row_ready = ($urandom_range(0, 99) < ready_pct);
      start     = 1'b0;
      lut_wr_en = 1'b0;
      if (mode == 1) row_ready = !(cyc >= 1 && cyc <= 3);
      if (mode == 2 && cyc == 2) begin
        start       = 1'b1;
        lut_wr_en   = 1'b1;
        lut_wr_fn   = 1'b0;
        lut_wr_data = ~model_lut[0];
      end
      step();
      if (cyc == 0) check("valid_after_start", 32'(s_valid), 32'd1);
      if (mode == 1 && cyc == 3) check("stalled_row_x", 32'(s_word[N_FN +: N_IN]), 32'd1);
      cyc++;
    end
    start     = 1'b0;
    lut_wr_en = 1'b0;
    row_ready = 1'b0;
    check("sweep_done_seen", 32'(done_cnt), 32'd1);
    check("all_rows_consumed", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
`ifdef TRUTH_TABLE_SEQ_MINTERM_COUNT_EN
    for (int f = 0; f < N_FN; f++)
      check("minterm_cnt", 32'(minterm_cnt[f*(N_IN+1) +: N_IN+1]), 32'(exp_cnt[f]));
`endif
    step();
    check("idle_after_done", 32'(s_state), 32'(ST_IDLE));
    step();
    check("no_restart", 32'(s_valid), 32'd0);
    check("single_done", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    n_checks = 0;  n_fail = 0;  done_cnt = 0;
    prev_done = 1'b0;  held_valid = 1'b0;  held_word = '0;
    reset = 1'b1;  start = 1'b0;  lut_wr_en = 1'b0;  lut_wr_fn = '0;
    lut_wr_data = '0;  row_ready = 1'b0;
    b_start = 1'b0;  b_wr_en = 1'b0;  b_wr_fn = '0;  b_wr_data = '0;  b_ready = 1'b0;
    for (int f = 0; f < N_FN; f++) model_lut[f] = '0;

    // reset state
    step();
    step();
    check("reset_valid", 32'(s_valid), 32'd0);
    check("reset_busy", 32'(s_busy), 32'd0);
    check("reset_done", 32'(s_done), 32'd0);
    check("reset_state", 32'(s_state), 32'(ST_IDLE));
    check("reset_row", 32'(s_word), 32'd0);
    reset = 1'b0;
    step();

    // directed sweep with always-ready consumer
    write_lut(0, 4'b0010, 1'b1);
    write_lut(1, 4'b1101, 1'b1);
    run_sweep(100, 0, 1'b0, '0);

    // backpressure on row 1
    run_sweep(100, 1, 1'b0, '0);

    // write and start during RUN are ignored; tables stay unchanged afterwards
    run_sweep(100, 2, 1'b0, '0);
    run_sweep(100, 0, 1'b0, '0);

    // reset aborts a sweep on row 2 and clears the tables
    push_expected();
    done_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    row_ready = 1'b1;
    step();
    step();
    row_ready = 1'b0;
    reset = 1'b1;
    step();
    check("row2_before_reset", 32'(s_word[N_FN +: N_IN]), 32'd2);
    reset = 1'b0;
    exp_q.delete();
    for (int f = 0; f < N_FN; f++) model_lut[f] = '0;
    step();
    check("abort_valid", 32'(s_valid), 32'd0);
    check("abort_busy", 32'(s_busy), 32'd0);
    check("abort_word", 32'(s_word), 32'd0);
    step();
    step();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_sweep(100, 0, 1'b0, '0);

    // random tables, random consumer throttling, sometimes writing on the start cycle
    for (int it = 0; it < 6; it++) begin
      write_lut(0, ROWS'($urandom()), 1'b1);
      if (it % 2 == 0) write_lut(1, ROWS'($urandom()), 1'b1);
      run_sweep($urandom_range(30, 100), 0, (it % 2 == 1), ROWS'($urandom()));
    end

    // XOR3 on the 3-input instance; a write to function index 1 must be dropped
    b_wr_en = 1'b1;  b_wr_fn = 1'b0;  b_wr_data = 8'h96;
    step();
    b_wr_fn = 1'b1;  b_wr_data = 8'hFF;
    step();
    b_wr_en = 1'b0;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    b_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("xor3_valid", 32'(b_valid), 32'd1);
      check("xor3_x", 32'(b_x), 32'(k));
      check("xor3_s", 32'(b_s), 32'($countones(k) % 2));
      check("xor3_last", 32'(b_last), 32'(k == 7));
      @(posedge clk);
      #1;
    end
    b_ready = 1'b0;
    @(negedge clk);
    check("xor3_done", 32'(b_done), 32'd1);
    check("xor3_busy_in_done", 32'(b_busy), 32'd0);
`ifdef TRUTH_TABLE_SEQ_MINTERM_COUNT_EN
    check("xor3_minterms", 32'(b_minterm_cnt), 32'd4);
`endif
    @(posedge clk);
    #1;
    @(negedge clk);
    check("xor3_done_cleared", 32'(b_done), 32'd0);
    check("xor3_idle", 32'(b_dbg_state), 32'(ST_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
